gpio_uart_tx: RTL and testbench

//   Host-facing end of the cpu gpio port. Watches the 32-bit gpio word driven
//   by cpu. Each change is queued in a small FIFO and sent off-chip as UART
//   8N1 frames, so a host or lab bench can log gpio traffic without a simulator.

---
 rtl/gpio_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx
//   Watches the cpu gpio word and sends every change off-chip as UART 8N1.
//   Changed words go into a small circular FIFO. Each word is sent as
//   DATA_WIDTH/8 frames, most significant byte first. Each byte is LSB first.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous reset, active low
//   gpio      cpu gpio word, synchronous to clk
//   enable    1 = queue changes, 0 = ignore them (last sample still tracks gpio)
//   tx        UART serial out, idle high, driven from a flop
//   busy      frame on the wire or FIFO not empty
//   overflow  sticky: a change was dropped because the FIFO was full
//   level     number of words currently queued
module gpio_uart_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_WIDTH-1:0]      gpio,
  input  logic                       enable,
  output logic                       tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [FIFO_ADDR_WIDTH:0]   level
);

  localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [FIFO_ADDR_WIDTH:0] FULL_LVL  = (FIFO_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [BYTE_W-1:0]        LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Capture stage: the compare result and the new word are registered, so a
  // change stable at edge n is written into the FIFO at edge n+1.
  logic [DATA_WIDTH-1:0] g_q;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_r;

  // FIFO
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic                       full;
  logic                       pop;
  logic                       wr_en;

  // Transmitter
  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [2:0]            bit_cnt;
  logic [BYTE_W-1:0]     byte_idx;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            cur_byte;

  assign full     = (level == FULL_LVL);
  assign pop      = (state == IDLE) && (level != '0);
  // A push into a full FIFO still lands when the same edge pops the head.
  assign wr_en    = push_r && (!full || pop);
  assign cur_byte = word[DATA_WIDTH-1 -: 8];
  assign busy     = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q       <= '0;
      push_data <= '0;
      push_r    <= 1'b0;
    end else begin
      g_q       <= gpio;
      push_data <= gpio;
      push_r    <= enable && (gpio != g_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_r && !wr_en) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      word     <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            word     <= mem[rd_ptr];
            byte_idx <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              word     <= word << 8;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4 and FIFO_ADDR_WIDTH=2.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_gpio_uart_tx;

  logic        clk;
  logic        reset_n;
  logic [31:0] gpio;
  logic        enable;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  level;

  int tests;
  int fails;

  gpio_uart_tx #(
    .DATA_WIDTH      (32),
    .CLKS_PER_BIT    (4),
    .FIFO_ADDR_WIDTH (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpio     (gpio),
    .enable   (enable),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host-side receiver: decodes one 32-bit word (4 frames, MSB byte first).
  // Must be entered at or before the start bit of the first byte.
  task automatic recv_word(output logic [31:0] w, output bit ok);
    int unsigned n;
    logic [7:0]  b;
    ok = 1'b1;
    w  = '0;
    b  = '0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (tx !== 1'b0 && n < 400) begin
        tick();
        n++;
      end
      if (tx !== 1'b0) begin
        ok = 1'b0;
        return;
      end
      repeat (2) tick();
      if (tx !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (4) tick();
        b[j] = tx;
      end
      repeat (4) tick();
      if (tx !== 1'b1) ok = 1'b0;
      w = {w[23:0], b};
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%b, required 0 within 2000 clks", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    gpio    = 32'h0;
    repeat (2) tick();
    gpio = 32'h1234_5678;
    tick();
    gpio = 32'hFFFF_0000;
    tick();
    gpio = 32'h0;
    tick();
    tests++;
    if ({tx, busy, level, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: tx=%b busy=%b level=%0d overflow=%b, required 1 0 0 0",
               tx, busy, level, overflow);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    tests++;
    if ({tx, busy, level} !== {1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_release: tx=%b busy=%b level=%0d, required 1 0 0", tx, busy, level);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    bit          ok;
    gpio = 32'h0000_700A;
    tick();
    tests++;
    if ({tx, busy, level} !== {1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL latency_edge_n: tx=%b busy=%b level=%0d, required 1 0 0", tx, busy, level);
    end
    tick();
    tests++;
    if ({tx, busy, level} !== {1'b1, 1'b1, 3'd1}) begin
      fails++;
      $display("FAIL latency_push: tx=%b busy=%b level=%0d, required 1 1 1", tx, busy, level);
    end
    tick();
    tests++;
    if ({tx, level} !== {1'b0, 3'd0}) begin
      fails++;
      $display("FAIL latency_pop: tx=%b level=%0d, required 0 0", tx, level);
    end
    recv_word(w, ok);
    tests++;
    if (!ok || w !== 32'h0000_700A) begin
      fails++;
      $display("FAIL single_word: got %h ok=%b, required 0000700a ok=1", w, ok);
    end
    tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL frame_len_159: busy=%b, required 1", busy);
    end
    tick();
    tests++;
    if ({busy, tx} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL frame_len_160: busy=%b tx=%b, required 0 1", busy, tx);
    end
  endtask

  task automatic test_burst();
    logic [31:0] got [5];
    logic [31:0] exp [5];
    bit          ok  [5];
    exp[0] = 32'h0000_00AA;
    exp[1] = 32'hFFFF_FFFF;
    exp[2] = 32'h0000_0001;
    exp[3] = 32'h0000_0006;
    exp[4] = 32'h0000_0007;
    // A lead word keeps the transmitter busy so the burst piles up.
    gpio = 32'h0000_00AA;
    repeat (3) tick();
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL burst_lead_start: tx=%b, required 0", tx);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) recv_word(got[i], ok[i]);
      end
      begin
        gpio = 32'hFFFF_FFFF;
        tick();
        gpio = 32'h0000_0001;
        tick();
        gpio = 32'h0000_0006;
        tick();
        gpio = 32'h0000_0007;
        tick();
        gpio = 32'hFFFF_FF00;
        tick();
        tests++;
        if ({level, overflow} !== {3'd4, 1'b0}) begin
          fails++;
          $display("FAIL burst_level_peak: level=%0d overflow=%b, required 4 0", level, overflow);
        end
        tick();
        tests++;
        if ({level, overflow} !== {3'd4, 1'b1}) begin
          fails++;
          $display("FAIL burst_drop: level=%0d overflow=%b, required 4 1", level, overflow);
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (!ok[i] || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL burst_word%0d: got %h ok=%b, required %h ok=1", i, got[i], ok[i], exp[i]);
      end
    end
    wait_idle("burst_drain");
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: overflow=%b, required 1", overflow);
    end
    reset_n = 1'b0;
    gpio    = 32'h0;
    #1;
    tests++;
    if ({overflow, level} !== {1'b0, 3'd0}) begin
      fails++;
      $display("FAIL overflow_clear: overflow=%b level=%0d, required 0 0", overflow, level);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_pop_collision();
    logic [31:0] got [5];
    logic [31:0] exp [5];
    bit          ok  [5];
    exp[0] = 32'h0000_00B2;
    exp[1] = 32'h0000_00C3;
    exp[2] = 32'h0000_00D4;
    exp[3] = 32'h0000_00E5;
    exp[4] = 32'h0000_00F6;
    gpio = 32'h0000_00A1;
    repeat (3) tick();             // word A popped here (edge P)
    gpio = exp[0];
    tick();
    gpio = exp[1];
    tick();
    gpio = exp[2];
    tick();
    gpio = exp[3];
    repeat (156) tick();           // P+159
    tests++;
    if ({level, overflow} !== {3'd4, 1'b0}) begin
      fails++;
      $display("FAIL full_before: level=%0d overflow=%b, required 4 0", level, overflow);
    end
    gpio = exp[4];                 // written at P+161, the next pop edge
    tick();
    tests++;
    if ({tx, level} !== {1'b1, 3'd4}) begin
      fails++;
      $display("FAIL full_idle_clk: tx=%b level=%0d, required 1 4", tx, level);
    end
    tick();
    tests++;
    if ({tx, level, overflow} !== {1'b0, 3'd4, 1'b0}) begin
      fails++;
      $display("FAIL full_pop_push: tx=%b level=%0d overflow=%b, required 0 4 0",
               tx, level, overflow);
    end
    for (int i = 0; i < 5; i++) recv_word(got[i], ok[i]);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (!ok[i] || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL collide_word%0d: got %h ok=%b, required %h ok=1", i, got[i], ok[i], exp[i]);
      end
    end
    wait_idle("collide_drain");
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL collide_overflow: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_enable_gating();
    logic [31:0] w;
    bit          ok;
    bit          tx_low;
    tx_low = 1'b0;
    enable = 1'b0;
    gpio   = 32'h0000_0006;
    tick();
    gpio = 32'h0000_0007;
    repeat (6) begin
      tick();
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    enable = 1'b1;
    repeat (20) begin
      tick();
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    tests++;
    if ({tx_low, busy, level} !== {1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL enable_gating: tx_low=%b busy=%b level=%0d, required 0 0 0",
               tx_low, busy, level);
    end
    gpio = 32'h00FF_0000;
    repeat (3) tick();
    recv_word(w, ok);
    tests++;
    if (!ok || w !== 32'h00FF_0000) begin
      fails++;
      $display("FAIL enable_resume: got %h ok=%b, required 00ff0000 ok=1", w, ok);
    end
    repeat (3) tick();
    tests++;
    if ({busy, level} !== {1'b0, 3'd0}) begin
      fails++;
      $display("FAIL enable_single: busy=%b level=%0d, required 0 0", busy, level);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    bit          ok;
    bit          tx_low;
    tx_low = 1'b0;
    gpio   = 32'h1234_5678;
    repeat (3) tick();             // edge P, first start bit
    repeat (85) tick();            // byte 2 (0x56), data bit 0 = 0
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL midframe_bit: tx=%b, required 0", tx);
    end
    reset_n = 1'b0;
    gpio    = 32'h0;
    #1;
    tests++;
    if ({tx, busy, level} !== {1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL midframe_abort: tx=%b busy=%b level=%0d, required 1 0 0", tx, busy, level);
    end
    tick();
    reset_n = 1'b1;
    repeat (50) begin
      tick();
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    tests++;
    if ({tx_low, busy} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midframe_residual: tx_low=%b busy=%b, required 0 0", tx_low, busy);
    end
    gpio = 32'hA5C3_0F81;
    repeat (3) tick();
    recv_word(w, ok);
    tests++;
    if (!ok || w !== 32'hA5C3_0F81) begin
      fails++;
      $display("FAIL midframe_next: got %h ok=%b, required a5c30f81 ok=1", w, ok);
    end
    wait_idle("midframe_drain");
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    enable  = 1'b1;
    gpio    = 32'h0;
    test_reset();
    test_single_word();
    test_burst();
    test_full_pop_collision();
    test_enable_gating();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
